data_mem_arbiter: RTL
=====================

// Module: data_mem_arbiter
// PURPOSE
//   Shares the single data-memory port between two requesters: m0 (core MEM stage load/store)
//   and m1 (program loader / debug access). Sequences non-pipelined memory accesses with
//   RD_LAT-cycle read latency. Registers read data and returns it to the owning requester.
//   Sits between MEM-stage/loader request ports and the data RAM.
// PARAMETERS
//   ADDR_W   32  address width, byte address, passed through unchanged
//   DATA_W   32  data width
//   RD_LAT   1   memory read latency in cycles, >=1; counter width $clog2(RD_LAT+1)
// PORTS
//   clk        in   1       clock; all state updates on rising edge
//   rst        in   1       synchronous reset, active-low
//   mN_req     in   1       request from requester N (N=0,1); held high until mN_gnt
//   mN_we      in   1       1=write, 0=read
//   mN_addr    in   ADDR_W  access address
//   mN_wdata   in   DATA_W  write data
//   mN_wstrb   in   4       byte write enables
//   mN_gnt     out  1       1-cycle pulse: request issued to memory this cycle
//   mN_rvalid  out  1       1-cycle pulse: mN_rdata valid (reads only)
//   mN_rdata   out  DATA_W  registered read data
//   mem_en     out  1       memory access strobe
//   mem_we     out  1       memory write enable
//   mem_addr   out  ADDR_W  memory address
//   mem_wdata  out  DATA_W  memory write data
//   mem_wstrb  out  4       memory byte enables
//   mem_rdata  in   DATA_W  memory read data, valid RD_LAT cycles after mem_en read
//   busy       out  1       high while in WAIT
// BEHAVIOUR
//   - Reset (rst==0 at edge): state=IDLE, wait counter=0, last_gnt=1 (m0 wins first tie),
//     m0/m1_rvalid=0, m0/m1_rdata=0, owner=0. Combinational outputs then follow IDLE with no
//     requests: gnt=0, mem_en=0, busy=0, mem_* buses=0.
//   - FSM states IDLE, WAIT.
//   - IDLE: if any req, pick winner combinationally. Same cycle: assert mN_gnt and mem_en,
//     and drive mem_we/addr/wdata/wstrb from the winner. With no winner all mem_* are 0.
//     - Write: stay IDLE; next grant possible next cycle; no rvalid generated.
//     - Read: record owner, load counter=RD_LAT, go to WAIT.
//   - WAIT: busy=1, no grants, mem_en=0; counter decrements each cycle.
//     On the last cycle (counter==1), capture mem_rdata into owner's rdata reg; go to IDLE.
//   - Owner's rvalid is high the cycle after capture, i.e. read granted at T -> rvalid at
//     T+RD_LAT+1. The non-owner's rdata register holds its value.
//     A new grant may occur in the same cycle rvalid is high (back-to-back).
//   - Arbitration (round-robin): one req -> grant it. Both -> grant requester != last_gnt.
//     last_gnt updates on every grant.
//   - Requests arriving during WAIT are held by the requester and arbitrated on return to IDLE.
//   - Dropping req before gnt is legal; the request is simply not seen. Address, data and
//     we are sampled only in the grant cycle.
//   - Reset mid-WAIT aborts the access: no rvalid and no rdata update.
// CONFIGURATION
//   DATA_MEM_ARB_FIXED_PRIO_EN defined: m0 always wins when both request (core never stalls
//     behind loader); last_gnt still tracked but unused.
//   Not defined: round-robin as above.
// TESTING
//   1 RD_LAT=1, mem[0x10]=0xDEADBEEF; m0 read 0x10 at T -> m0_gnt,mem_en,mem_addr=0x10 @T;
//     busy @T+1; m0_rvalid=1, m0_rdata=0xDEADBEEF @T+2; m1_rvalid stays 0.
//   2 After reset, m0 and m1 both hold write req continuously -> grants alternate
//     m0,m1,m0,m1 on consecutive cycles; mem_we=1 each cycle.
//   3 m1 write addr 0x20, wdata 0x12345678, wstrb 4'b0011 -> mem_we=1, mem_wstrb=0011 that
//     cycle; no rvalid; m0 read granted next cycle.
//   4 RD_LAT=3: m0 read at T; m1 read req raised @T+1 -> m1_gnt=0 during WAIT;
//     m0_rvalid @T+4 and m1_gnt same cycle; m1_rvalid @T+8.
//   5 RD_LAT=3: rst=0 @T+2 during m0 read -> state IDLE @T+3, busy=0; no m0_rvalid ever;
//     m0_rdata=0.
//   6 Macro defined: both hold write req for 4 cycles -> m0_gnt all 4 cycles, m1_gnt=0;
//     m0 drops req -> m1_gnt next cycle.

Source files
------------

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter
//   Shares one non-pipelined data-memory port between m0 (core MEM stage) and
//   m1 (program loader / debug). A read holds the port for RD_LAT cycles. The
//   returned data is registered and handed back to whichever requester issued
//   the read.
//
//   Ports
//     clk, rst           clock; synchronous reset, active-low
//     mN_req/we/addr/    requester N (N=0,1). The requester holds req high until
//       wdata/wstrb      it sees gnt. The other fields are sampled only in the
//                        grant cycle.
//     mN_gnt             1-cycle pulse: this requester's access goes to memory now
//     mN_rvalid/rdata    1-cycle read-return pulse and registered read data
//     mem_*              memory strobe/command, driven straight from the winner
//     mem_rdata          read data, valid RD_LAT cycles after a read strobe
//     busy               high while waiting on read latency
//
//   Configuration
//     DATA_MEM_ARB_FIXED_PRIO_EN  defined: m0 always wins a tie.
//                                 undefined: round-robin on ties.
module data_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [3:0]        m0_wstrb,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [3:0]        m1_wstrb,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int CNT_W = $clog2(RD_LAT + 1);

`ifdef DATA_MEM_ARB_FIXED_PRIO_EN
  localparam logic RR_EN = 1'b0;
`else
  localparam logic RR_EN = 1'b1;
`endif

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             last_gnt;  // 0: m0 granted last, 1: m1 granted last
  logic             owner;     // requester waiting on the read in flight

  logic idle, m0_win;

  assign idle = (state == S_IDLE);
  assign busy = (state == S_WAIT);

  // m0 wins when alone, or on a tie when m1 had the last grant. With round-robin
  // off the tie always goes to m0. last_gnt is still tracked in that case.
  assign m0_win = m0_req & (~m1_req | last_gnt | ~RR_EN);
  assign m0_gnt = idle & m0_win;
  assign m1_gnt = idle & m1_req & ~m0_win;
  assign mem_en = m0_gnt | m1_gnt;

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    if (m0_gnt) begin
      mem_we    = m0_we;
      mem_addr  = m0_addr;
      mem_wdata = m0_wdata;
      mem_wstrb = m0_wstrb;
    end else if (m1_gnt) begin
      mem_we    = m1_we;
      mem_addr  = m1_addr;
      mem_wdata = m1_wdata;
      mem_wstrb = m1_wstrb;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      last_gnt  <= 1'b1;
      owner     <= 1'b0;
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
    end else begin
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (mem_en) begin
            last_gnt <= m1_gnt;
            // Writes complete in the grant cycle. Only reads occupy the port.
            if (!mem_we) begin
              owner <= m1_gnt;
              cnt   <= CNT_W'(RD_LAT);
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            state <= S_IDLE;
            if (owner) begin
              m1_rdata  <= mem_rdata;
              m1_rvalid <= 1'b1;
            end else begin
              m0_rdata  <= mem_rdata;
              m0_rvalid <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
